// File: rtl/alu_stream_if.sv
// Operand/result stream bundle for alu_stream. Optional zero/ovf flag signals
// are present only when ALU_STREAM_FLAGS_EN is defined.
interface alu_stream_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_0;
  logic [WIDTH-1:0] in_1;
  logic             M_0;
  logic             M_1;
  logic             c_in;
  logic             chain;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             c_out;
  logic [CW-1:0]    count;
`ifdef ALU_STREAM_FLAGS_EN
  logic             zero;
  logic             ovf;
`endif

  modport master (
    output in_valid, in_0, in_1, M_0, M_1, c_in, chain, out_ready,
`ifdef ALU_STREAM_FLAGS_EN
    input  zero, ovf,
`endif
    input  in_ready, out_valid, out, c_out, count
  );

  modport slave (
    input  in_valid, in_0, in_1, M_0, M_1, c_in, chain, out_ready,
`ifdef ALU_STREAM_FLAGS_EN
    output zero, ovf,
`endif
    output in_ready, out_valid, out, c_out, count
  );
endinterface

// File: rtl/alu_stream.sv
// Pipelined WIDTH-bit ADD/SUB/AND/XOR unit with chained carry and a DEPTH-entry
// result FIFO. Define ALU_STREAM_FLAGS_EN to store and present zero/ovf flags.
module alu_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  alu_stream_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             mem_c [DEPTH];
`ifdef ALU_STREAM_FLAGS_EN
  logic             mem_z [DEPTH];
  logic             mem_v [DEPTH];
  logic             ovf_w;
`endif
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             carry_q;

  logic             push;
  logic             pop;
  logic             cin_eff;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_c;

  assign bus.in_ready  = (count_q < CW'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign bus.count     = count_q;
  assign bus.out       = mem_r[rd_ptr];
  assign bus.c_out     = mem_c[rd_ptr];
`ifdef ALU_STREAM_FLAGS_EN
  assign bus.zero      = mem_z[rd_ptr];
  assign bus.ovf       = mem_v[rd_ptr];
`endif

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // SUB reuses the adder with an inverted B operand; carry-in 1 means no borrow-in.
  always_comb begin
    cin_eff = bus.chain ? carry_q : bus.c_in;
    op_b    = bus.M_0 ? ~bus.in_1 : bus.in_1;
    sum     = {1'b0, bus.in_0} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin_eff};
    res     = sum[WIDTH-1:0];
    res_c   = sum[WIDTH];
    case ({bus.M_1, bus.M_0})
      2'b10: begin
        res   = bus.in_0 & bus.in_1;
        res_c = 1'b0;
      end
      2'b11: begin
        res   = bus.in_0 ^ bus.in_1;
        res_c = 1'b0;
      end
      default: ;
    endcase
`ifdef ALU_STREAM_FLAGS_EN
    ovf_w = !bus.M_1 && (bus.in_0[WIDTH-1] == op_b[WIDTH-1])
            && (res[WIDTH-1] != bus.in_0[WIDTH-1]);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
        mem_c[i] <= 1'b0;
`ifdef ALU_STREAM_FLAGS_EN
        mem_z[i] <= 1'b0;
        mem_v[i] <= 1'b0;
`endif
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
    end else begin
      if (push) begin
        mem_r[wr_ptr] <= res;
        mem_c[wr_ptr] <= res_c;
`ifdef ALU_STREAM_FLAGS_EN
        mem_z[wr_ptr] <= (res == '0);
        mem_v[wr_ptr] <= ovf_w;
`endif
        wr_ptr <= wr_ptr + PW'(1);
        // Logic ops leave the chain carry untouched.
        if (!bus.M_1) carry_q <= res_c;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_stream.sv
// Scoreboard bench for alu_stream (WIDTH=8, DEPTH=4); flag checks are active
// when ALU_STREAM_FLAGS_EN is defined.
module tb_alu_stream;
  typedef struct packed {
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  alu_stream_if #(.WIDTH(8), .DEPTH(4)) bus ();

  alu_stream #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is taken from the FIFO head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(bus.out), 32'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out", 32'(bus.out), 32'(e.r));
        check("c_out", 32'(bus.c_out), 32'(e.c));
`ifdef ALU_STREAM_FLAGS_EN
        check("zero", 32'(bus.zero), 32'(e.z));
        check("ovf", 32'(bus.ovf), 32'(e.v));
`endif
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                      input logic ci, input logic ch, input logic do_push,
                      input logic [7:0] er, input logic ec, input logic ez, input logic ev);
    int   budget;
    logic accepted;
    exp_t e;
    budget   = 0;
    accepted = 1'b0;
    bus.in_0 = a;
    bus.in_1 = b;
    bus.M_1  = m[1];
    bus.M_0  = m[0];
    bus.c_in = ci;
    bus.chain = ch;
    bus.in_valid = 1'b1;
    while (!accepted && budget < 20) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepted = 1'b1;
        if (do_push) begin
          e.r = er; e.c = ec; e.z = ez; e.v = ev;
          exp_q.push_back(e);
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    bus.in_valid = 1'b0;
    if (!accepted) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    bus.out_ready = 1'b1;
    while (bus.count != 0 && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check("drain_count", 32'(bus.count), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_0 = '0; bus.in_1 = '0;
    bus.M_0 = 1'b0; bus.M_1 = 1'b0;
    bus.c_in = 1'b0; bus.chain = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_c_out", 32'(bus.c_out), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    send(8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);

    // ADD with carry out, result visible one edge after acceptance
    send(8'hFF, 8'h01, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    check("lat_out_valid", 32'(bus.out_valid), 32'd1);
    check("lat_out", 32'(bus.out), 32'h00);
    check("lat_c_out", 32'(bus.c_out), 32'd1);

    // XOR keeps carry_q; chained ADD consumes it
    send(8'h0F, 8'hF0, 2'b11, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    send(8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);

    // SUB / flags
    send(8'h05, 8'h07, 2'b01, 1'b1, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    send(8'h7F, 8'h01, 2'b00, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
    send(8'hF0, 8'h0F, 2'b10, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    send(8'h07, 8'h05, 2'b01, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
    send(8'h00, 8'h00, 2'b01, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    send(8'h80, 8'h01, 2'b01, 1'b1, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;

    // Backpressure: fill to full
    bus.out_ready = 1'b0;
    send(8'h10, 8'h01, 2'b00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    send(8'h20, 8'h02, 2'b00, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    send(8'h30, 8'h03, 2'b00, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    send(8'h40, 8'h04, 2'b00, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    check("full_count", 32'(bus.count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_0 = 8'h50; bus.in_1 = 8'h05; bus.M_0 = 1'b0; bus.M_1 = 1'b0;
    bus.chain = 1'b0; bus.c_in = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    check("full_ignore_count", 32'(bus.count), 32'd4);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("full_pushpop_count", 32'(bus.count), 32'd3);
    bus.in_valid = 1'b0;
    drain();

    // Reset in the middle of a stream clears FIFO and carry_q asynchronously
    bus.out_ready = 1'b0;
    send(8'hFF, 8'h01, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h01, 8'h01, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h03, 8'h01, 2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", 32'(bus.count), 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(bus.count), 32'd0);
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    send(8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk); #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_stream.md
Name: alu_stream

Overview:
- Parametrised, pipelined successor to the team's combinational 3-bit ALU.
- Same operand, mode and carry interface (in_0, in_1, M_0, M_1, c_in, out, c_out), generalised to WIDTH bits.
- Adds a valid/ready handshake, an internal carry register for multi-word (chained) arithmetic, and a result FIFO of DEPTH entries.
- Sits between an operand producer and a result consumer in the datapath.

Parameters:
- WIDTH, 8: operand/result width in bits, >= 2.
- DEPTH, 4: result FIFO entries, >= 2, power of two.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block can accept a beat.
- in_0  in  WIDTH  operand A.
- in_1  in  WIDTH  operand B.
- M_0  in  1  mode bit 0.
- M_1  in  1  mode bit 1.
- c_in  in  1  external carry-in.
- chain  in  1  1 = use stored carry register instead of c_in.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out  out  WIDTH  result at FIFO head.
- c_out  out  1  carry at FIFO head.
- count  out  $clog2(DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (async, rst_n low): FIFO pointers = 0, count = 0, out_valid = 0, out = 0, c_out = 0, carry_q = 0. in_ready = 1 once rst_n is high.
- Accept when in_valid && in_ready. Pop when out_valid && out_ready.
- in_ready = (count < DEPTH). No combinational ready pass-through: when full, a simultaneous pop does not allow a push in that cycle.
- Effective carry: cin_eff = chain ? carry_q : c_in.
- Ops, selected by {M_1,M_0}, computed in WIDTH+1 bits:
  - 00 ADD: {c, r} = in_0 + in_1 + cin_eff.
  - 01 SUB: {c, r} = in_0 + ~in_1 + cin_eff. c = 1 means no borrow; cin_eff = 1 means no borrow-in.
  - 10 AND: r = in_0 & in_1, c = 0.
  - 11 XOR: r = in_0 ^ in_1, c = 0.
- Each accepted beat writes {r, c} into the FIFO tail in the same cycle.
- Latency: the result is visible on out/c_out/out_valid on the first rising edge after acceptance when the FIFO is empty. Otherwise results come out in FIFO order.
- carry_q: on an accepted ADD/SUB, carry_q <= c. On an accepted AND/XOR, carry_q is unchanged. Without an accepted beat, it holds.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Empty: out_valid = 0; out/c_out hold their last value (don't-care to the consumer).
- Full: in_ready = 0; in_valid is ignored with no state change.
- Pop with out_valid = 0: no effect.
- Reset mid-operation: all FIFO contents discarded immediately; carry_q cleared.

Optional Feature:
- Macro ALU_STREAM_FLAGS_EN.
- When defined:
  - Adds outputs zero (1 bit) and ovf (1 bit), stored per FIFO entry and presented alongside out.
  - zero = (r == 0).
  - ovf = signed overflow for ADD/SUB (operand signs equal and result sign differs, using ~in_1 for SUB); ovf = 0 for AND/XOR.
  - Both reset to 0.
- When undefined: ports, storage and logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8, DEPTH=4):
1. Reset: hold rst_n low, then release -> out_valid=0, count=0, in_ready=1, c_out=0; first chained ADD 0x00+0x00 gives out=0x00, c_out=0 (carry_q=0).
2. ADD: in_0=0xFF, in_1=0x01, c_in=0, chain=0 -> next cycle out=0x00, c_out=1, out_valid=1.
3. Chain: after step 2, ADD in_0=0x00, in_1=0x00, chain=1 -> out=0x01, c_out=0. An intervening XOR must not disturb carry_q.
4. SUB: in_0=0x05, in_1=0x07, c_in=1 -> out=0xFE, c_out=0. With ALU_STREAM_FLAGS_EN defined: zero=0, ovf=0. Also ADD 0x7F+0x01 -> out=0x80, ovf=1.
5. Backpressure: out_ready=0, offer 5 beats -> 4 accepted, count=4, in_ready=0. Push+pop when full -> no push. Then drain -> results in order, count back to 0.
6. Reset mid-stream: count=3, pulse rst_n low between clock edges -> out_valid and count drop to 0 immediately, without waiting for a clock edge.
